// File: rtl/mux_branch.sv
// Next-PC select for fetch: combinational PC mux, registered copy and taken-branch counter.
// Latency: PC/misaligned are combinational; PC_q and taken_count update one edge later.
// No backpressure: Hold freezes the registered state; PC keeps tracking the inputs.
module mux_branch #(
    parameter int WIDTH     = 12,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     AdderOut,
    input  logic [WIDTH-1:0]     AddALUOut,
    input  logic                 Select,
    input  logic                 Hold,
    output logic [WIDTH-1:0]     PC,
    output logic [WIDTH-1:0]     PC_q,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic                 misaligned
);

    localparam logic [CNT_WIDTH-1:0] countMax = '1;

    logic countSat;

    assign PC         = Select ? AddALUOut : AdderOut;
    assign misaligned = Select & (AddALUOut[1:0] != 2'b00);
    assign countSat   = (taken_count == countMax);

    // Reset takes priority over Hold so a stalled pipeline can still be flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_q        <= '0;
            taken_count <= '0;
        end else if (!Hold) begin
            PC_q <= PC;
            if (Select && !countSat) begin
                taken_count <= taken_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_branch.sv
// Randomised and directed checks of mux_branch against a counting reference model.
module tb_mux_branch;

    logic        clk;
    logic        clkEn;
    logic        reset;
    logic [11:0] AdderOut;
    logic [11:0] AddALUOut;
    logic        Select;
    logic        Hold;

    logic [11:0] PC, PC_q;
    logic [15:0] taken_count;
    logic        misaligned;

    logic [11:0] pc4, pcq4;
    logic [3:0]  cnt4;
    logic        mis4;

    int vectors;
    int miscompares;

    // Reference state: last latched address and the raw number of taken, unstalled edges.
    logic [11:0] mPcq;
    int          mTaken;
    bit          mValid;

    mux_branch dut (
        .clk(clk), .reset(reset), .AdderOut(AdderOut), .AddALUOut(AddALUOut),
        .Select(Select), .Hold(Hold), .PC(PC), .PC_q(PC_q),
        .taken_count(taken_count), .misaligned(misaligned)
    );

    mux_branch #(.WIDTH(12), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .AdderOut(AdderOut), .AddALUOut(AddALUOut),
        .Select(Select), .Hold(Hold), .PC(pc4), .PC_q(pcq4),
        .taken_count(cnt4), .misaligned(mis4)
    );

    initial begin
        clk = 1'b0;
        wait (clkEn);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mPcq   <= 12'h000;
            mTaken <= 0;
            mValid <= 1'b1;
        end else if (!Hold) begin
            mPcq <= Select ? AddALUOut : AdderOut;
            if (Select) mTaken <= mTaken + 1;
        end
    end

    always @(negedge clk) begin
        logic [11:0] expPc;
        logic        expMis;
        int          sat16, sat4;
        expPc  = Select ? AddALUOut : AdderOut;
        expMis = Select && (AddALUOut % 4 != 0);
        chk("PC", 32'(PC), 32'(expPc));
        chk("misaligned", 32'(misaligned), 32'(expMis));
        chk("PC_cnt4", 32'(pc4), 32'(expPc));
        chk("misaligned_cnt4", 32'(mis4), 32'(expMis));
        if (mValid) begin
            sat16 = (mTaken > 65535) ? 65535 : mTaken;
            sat4  = (mTaken > 15) ? 15 : mTaken;
            chk("PC_q", 32'(PC_q), 32'(mPcq));
            chk("taken_count", 32'(taken_count), 32'(sat16));
            chk("PC_q_cnt4", 32'(pcq4), 32'(mPcq));
            chk("taken_count_cnt4", 32'(cnt4), 32'(sat4));
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mValid      = 1'b0;
        mPcq        = 12'h000;
        mTaken      = 0;
        clkEn       = 1'b0;
        reset       = 1'b0;
        Hold        = 1'b0;
        AdderOut    = 12'h000;
        AddALUOut   = 12'h01F;
        Select      = 1'b0;

        // Combinational path before any clock exists.
        #1 chk("pc_noclk_seq", 32'(PC), 32'h000);
        #9 Select = 1'b1;
        #1 chk("pc_noclk_br", 32'(PC), 32'h01F);
        clkEn = 1'b1;

        // Reset with arbitrary inputs, including Hold asserted.
        reset     = 1'b1;
        Hold      = 1'b1;
        AdderOut  = 12'($urandom);
        AddALUOut = 12'($urandom);
        Select    = 1'($urandom);
        step();
        chk("rst_pcq", 32'(PC_q), 32'h000);
        chk("rst_cnt", 32'(taken_count), 32'h0);

        reset     = 1'b0;
        Hold      = 1'b0;
        Select    = 1'b1;
        AddALUOut = 12'h404;
        repeat (3) step();
        chk("br3_pcq", 32'(PC_q), 32'h404);
        chk("br3_cnt", 32'(taken_count), 32'h3);

        // Stall: registers frozen, PC keeps following the inputs.
        Hold = 1'b1;
        repeat (4) begin
            Select    = 1'($urandom);
            AdderOut  = 12'($urandom);
            AddALUOut = 12'($urandom);
            step();
        end
        chk("hold_pcq", 32'(PC_q), 32'h404);
        chk("hold_cnt", 32'(taken_count), 32'h3);

        Select    = 1'b1;
        AddALUOut = 12'h102;
        #1 chk("mis_102", 32'(misaligned), 32'h1);
        AddALUOut = 12'h100;
        #1 chk("mis_100", 32'(misaligned), 32'h0);
        Select    = 1'b0;
        AddALUOut = 12'h102;
        #1 chk("mis_sel0", 32'(misaligned), 32'h0);
        step();

        // Saturation of the narrow counter.
        reset = 1'b1;
        Hold  = 1'b0;
        step();
        reset  = 1'b0;
        Select = 1'b1;
        repeat (20) step();
        chk("sat_cnt4", 32'(cnt4), 32'hF);
        chk("sat_cnt16", 32'(taken_count), 32'd20);

        // Reset beats Hold.
        Select   = 1'b0;
        AdderOut = 12'hABC;
        step();
        chk("pre_rst_pcq", 32'(PC_q), 32'hABC);
        reset = 1'b1;
        Hold  = 1'b1;
        step();
        chk("rst_hold_pcq", 32'(PC_q), 32'h000);
        chk("rst_hold_cnt", 32'(taken_count), 32'h0);
        reset = 1'b0;
        Hold  = 1'b0;

        repeat (400) begin
            AdderOut  = 12'($urandom);
            AddALUOut = 12'($urandom);
            Select    = 1'($urandom);
            Hold      = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 49) == 0);
            step();
        end

        reset = 1'b0;
        Hold  = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
